// File: rtl/timer_ctrl.sv
// Front-panel sequencer for the mm:ss countdown: button pulses drive preset entry,
// start/pause/abort, counter load/enable control and the timeout alarm.
module timer_ctrl #(
    parameter int ALARM_CYCLES = 50_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_set,
    input  logic       btn_inc,
    input  logic       btn_start,
    input  logic [3:0] min_hi,
    input  logic [3:0] min_lo,
    input  logic [2:0] sec_hi,
    input  logic [3:0] sec_lo,
    output logic       enabled,
    output logic       paused,
    output logic [3:0] hi,
    output logic [3:0] lo,
    output logic       seconds,
    output logic       alarm,
    output logic [2:0] state_o
);

    localparam int CW = (ALARM_CYCLES < 2) ? 1 : $clog2(ALARM_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SET_MIN = 3'd1,
        SET_SEC = 3'd2,
        RUN     = 3'd3,
        PAUSE   = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t        state_reg, state_next;
    logic [3:0]    pm_hi_reg, pm_hi_next;
    logic [3:0]    pm_lo_reg, pm_lo_next;
    logic [2:0]    ps_hi_reg, ps_hi_next;
    logic [3:0]    ps_lo_reg, ps_lo_next;
    logic          enabled_reg, enabled_next;
    logic          paused_reg, paused_next;
    logic          seconds_reg, seconds_next;
    logic [3:0]    hi_reg, hi_next;
    logic [3:0]    lo_reg, lo_next;
    logic          alarm_reg, alarm_next;
    logic [CW-1:0] alarm_cnt_reg, alarm_cnt_next;
    logic [1:0]    mask_cnt_reg, mask_cnt_next;

    logic preset_zero;
    logic digits_zero;

    assign preset_zero = (pm_hi_reg == 4'd0) && (pm_lo_reg == 4'd0) &&
                         (ps_hi_reg == 3'd0) && (ps_lo_reg == 4'd0);
    assign digits_zero = (min_hi == 4'd0) && (min_lo == 4'd0) &&
                         (sec_hi == 3'd0) && (sec_lo == 4'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            pm_hi_reg     <= 4'd0;
            pm_lo_reg     <= 4'd0;
            ps_hi_reg     <= 3'd0;
            ps_lo_reg     <= 4'd0;
            enabled_reg   <= 1'b0;
            paused_reg    <= 1'b0;
            seconds_reg   <= 1'b0;
            hi_reg        <= 4'd0;
            lo_reg        <= 4'd0;
            alarm_reg     <= 1'b0;
            alarm_cnt_reg <= '0;
            mask_cnt_reg  <= 2'd0;
        end else begin
            state_reg     <= state_next;
            pm_hi_reg     <= pm_hi_next;
            pm_lo_reg     <= pm_lo_next;
            ps_hi_reg     <= ps_hi_next;
            ps_lo_reg     <= ps_lo_next;
            enabled_reg   <= enabled_next;
            paused_reg    <= paused_next;
            seconds_reg   <= seconds_next;
            hi_reg        <= hi_next;
            lo_reg        <= lo_next;
            alarm_reg     <= alarm_next;
            alarm_cnt_reg <= alarm_cnt_next;
            mask_cnt_reg  <= mask_cnt_next;
        end
    end

    // Next state and preset editing; a start pulse swallows coincident set/inc.
    always_comb begin
        state_next = state_reg;
        pm_hi_next = pm_hi_reg;
        pm_lo_next = pm_lo_reg;
        ps_hi_next = ps_hi_reg;
        ps_lo_next = ps_lo_reg;
        case (state_reg)
            IDLE: begin
                if (btn_start) begin
                    if (!preset_zero) state_next = RUN;
                end else if (btn_set) begin
                    state_next = SET_MIN;
                end
            end
            SET_MIN: begin
                if (!btn_start) begin
                    if (btn_set) begin
                        state_next = SET_SEC;
                    end else if (btn_inc) begin
                        if (pm_lo_reg == 4'd9) begin
                            pm_lo_next = 4'd0;
                            pm_hi_next = (pm_hi_reg == 4'd9) ? 4'd0 : pm_hi_reg + 4'd1;
                        end else begin
                            pm_lo_next = pm_lo_reg + 4'd1;
                        end
                    end
                end
            end
            SET_SEC: begin
                if (!btn_start) begin
                    if (btn_set) begin
                        state_next = IDLE;
                    end else if (btn_inc) begin
                        if (ps_lo_reg == 4'd9) begin
                            ps_lo_next = 4'd0;
                            ps_hi_next = (ps_hi_reg == 3'd5) ? 3'd0 : ps_hi_reg + 3'd1;
                        end else begin
                            ps_lo_next = ps_lo_reg + 4'd1;
                        end
                    end
                end
            end
            RUN: begin
                if (btn_start)                               state_next = PAUSE;
                else if (btn_set)                            state_next = IDLE;
                else if (mask_cnt_reg == 2'd0 && digits_zero) state_next = DONE;
            end
            PAUSE: begin
                if (btn_start)    state_next = RUN;
                else if (btn_set) state_next = IDLE;
            end
            DONE: begin
                if (btn_start) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Registered outputs follow the state being entered.
    always_comb begin
        enabled_next   = enabled_reg;
        paused_next    = paused_reg;
        seconds_next   = seconds_reg;
        hi_next        = hi_reg;
        lo_next        = lo_reg;
        alarm_next     = 1'b0;
        alarm_cnt_next = '0;
        mask_cnt_next  = 2'd0;
        case (state_next)
            SET_MIN: begin
                enabled_next = 1'b0;
                paused_next  = 1'b0;
                seconds_next = 1'b0;
                hi_next      = pm_hi_next;
                lo_next      = pm_lo_next;
            end
            SET_SEC: begin
                enabled_next = 1'b0;
                paused_next  = 1'b0;
                seconds_next = 1'b1;
                hi_next      = {1'b0, ps_hi_next};
                lo_next      = ps_lo_next;
            end
            RUN: begin
                enabled_next = 1'b1;
                paused_next  = 1'b0;
                // Counter outputs lag the enable, so hold off zero detect after a fresh start.
                if (state_reg == IDLE)
                    mask_cnt_next = 2'd2;
                else if (state_reg == RUN && mask_cnt_reg != 2'd0)
                    mask_cnt_next = mask_cnt_reg - 2'd1;
            end
            PAUSE: begin
                enabled_next = 1'b1;
                paused_next  = 1'b1;
            end
            default: begin
                // IDLE and DONE alternate the load field so both fields refresh.
                enabled_next = 1'b0;
                paused_next  = 1'b0;
                seconds_next = ~seconds_reg;
                hi_next      = seconds_reg ? pm_hi_next : {1'b0, ps_hi_next};
                lo_next      = seconds_reg ? pm_lo_next : ps_lo_next;
                if (state_next == DONE) begin
                    if (state_reg != DONE) begin
                        alarm_next     = 1'b1;
                        alarm_cnt_next = CW'(ALARM_CYCLES - 1);
                    end else if (alarm_cnt_reg != '0) begin
                        alarm_next     = 1'b1;
                        alarm_cnt_next = alarm_cnt_reg - 1'b1;
                    end
                end
            end
        endcase
    end

    assign enabled = enabled_reg;
    assign paused  = paused_reg;
    assign seconds = seconds_reg;
    assign hi      = hi_reg;
    assign lo      = lo_reg;
    assign alarm   = alarm_reg;
    assign state_o = state_reg;

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed bench for timer_ctrl: preset entry, run/pause/abort, zero detect,
// alarm length, button priority and asynchronous reset.
`timescale 1ns/100ps
module tb_timer_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_set = 1'b0, btn_inc = 1'b0, btn_start = 1'b0;
    logic [3:0] min_hi = 4'd0, min_lo = 4'd0, sec_lo = 4'd0;
    logic [2:0] sec_hi = 3'd0;
    logic       enabled, paused, seconds, alarm;
    logic [3:0] hi, lo;
    logic [2:0] state_o;

    int total = 0;
    int bad = 0;

    timer_ctrl #(.ALARM_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .btn_set(btn_set), .btn_inc(btn_inc), .btn_start(btn_start),
        .min_hi(min_hi), .min_lo(min_lo), .sec_hi(sec_hi), .sec_lo(sec_lo),
        .enabled(enabled), .paused(paused), .hi(hi), .lo(lo),
        .seconds(seconds), .alarm(alarm), .state_o(state_o)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    // One button pulse, captured at the next rising edge; returns at the following negedge.
    task automatic press(input logic s, input logic i, input logic st);
        @(negedge clk);
        btn_set = s; btn_inc = i; btn_start = st;
        @(negedge clk);
        btn_set = 1'b0; btn_inc = 1'b0; btn_start = 1'b0;
    endtask

    task automatic set_digits(input logic [3:0] mh, input logic [3:0] ml,
                              input logic [2:0] sh, input logic [3:0] sl);
        min_hi = mh; min_lo = ml; sec_hi = sh; sec_lo = sl;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        total++;
        if ({state_o, enabled, paused, seconds, alarm, hi, lo} !== 15'd0) begin
            bad++;
            $display("FAIL reset_outputs: got %h want 0", {state_o, enabled, paused, seconds, alarm, hi, lo});
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if ({state_o, enabled, hi, lo} !== 12'd0) begin
            bad++;
            $display("FAIL idle_after_reset: got %h want 0", {state_o, enabled, hi, lo});
        end
        $display("test_reset: total=%0d bad=%0d", total, bad);
    endtask

    task automatic test_preset;
        logic prev_sec;
        press(1, 0, 0);
        for (int k = 0; k < 12; k++) press(0, 1, 0);
        total++;
        if ({state_o, seconds, hi, lo} !== {3'd1, 1'b0, 4'd1, 4'd2}) begin
            bad++;
            $display("FAIL set_min_12: got st=%0d s=%0d %0d%0d want st=1 s=0 12", state_o, seconds, hi, lo);
        end
        press(1, 0, 0);
        for (int k = 0; k < 61; k++) press(0, 1, 0);
        total++;
        if ({state_o, seconds, hi, lo} !== {3'd2, 1'b1, 4'd0, 4'd1}) begin
            bad++;
            $display("FAIL set_sec_01: got st=%0d s=%0d %0d%0d want st=2 s=1 01", state_o, seconds, hi, lo);
        end
        press(1, 0, 0);
        prev_sec = seconds;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            total++;
            if (state_o !== 3'd0 || seconds !== ~prev_sec ||
                {hi, lo} !== (seconds ? 8'h01 : 8'h12)) begin
                bad++;
                $display("FAIL idle_reload: got st=%0d s=%0d hilo=%h want st=0 s=%0d hilo=%h",
                         state_o, seconds, {hi, lo}, ~prev_sec, (~prev_sec ? 8'h01 : 8'h12));
            end
            prev_sec = seconds;
        end
        $display("test_preset: total=%0d bad=%0d", total, bad);
    endtask

    task automatic test_pause_abort;
        set_digits(4'd1, 4'd2, 3'd0, 4'd1);
        press(0, 0, 1);
        total++;
        if ({state_o, enabled, paused} !== {3'd3, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL run_entry: got st=%0d en=%0d p=%0d want st=3 en=1 p=0", state_o, enabled, paused);
        end
        press(0, 0, 1);
        set_digits(4'd0, 4'd0, 3'd0, 4'd0);
        repeat (3) @(negedge clk);
        total++;
        if ({state_o, enabled, paused} !== {3'd4, 1'b1, 1'b1}) begin
            bad++;
            $display("FAIL pause_hold: got st=%0d en=%0d p=%0d want st=4 en=1 p=1", state_o, enabled, paused);
        end
        set_digits(4'd1, 4'd0, 3'd0, 4'd5);
        press(0, 0, 1);
        total++;
        if ({state_o, enabled, paused} !== {3'd3, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL resume: got st=%0d en=%0d p=%0d want st=3 en=1 p=0", state_o, enabled, paused);
        end
        press(1, 0, 0);
        total++;
        if ({state_o, enabled} !== {3'd0, 1'b0}) begin
            bad++;
            $display("FAIL abort: got st=%0d en=%0d want st=0 en=0", state_o, enabled);
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            total++;
            if ({hi, lo} !== (seconds ? 8'h01 : 8'h12)) begin
                bad++;
                $display("FAIL abort_reload: got s=%0d hilo=%h want %h", seconds, {hi, lo}, (seconds ? 8'h01 : 8'h12));
            end
        end
        $display("test_pause_abort: total=%0d bad=%0d", total, bad);
    endtask

    task automatic test_priority;
        press(1, 1, 1);
        total++;
        if (state_o !== 3'd3) begin
            bad++;
            $display("FAIL start_wins: got st=%0d want 3", state_o);
        end
        press(1, 0, 0);
        press(1, 0, 0);
        total++;
        if ({state_o, hi, lo} !== {3'd1, 4'd1, 4'd2}) begin
            bad++;
            $display("FAIL preset_kept: got st=%0d %0d%0d want st=1 12", state_o, hi, lo);
        end
        press(1, 1, 0);
        total++;
        if ({state_o, hi, lo} !== {3'd2, 4'd0, 4'd1}) begin
            bad++;
            $display("FAIL set_over_inc: got st=%0d %0d%0d want st=2 01", state_o, hi, lo);
        end
        press(1, 0, 0);
        press(1, 0, 0);
        total++;
        if ({state_o, hi, lo} !== {3'd1, 4'd1, 4'd2}) begin
            bad++;
            $display("FAIL pm_unchanged: got st=%0d %0d%0d want st=1 12", state_o, hi, lo);
        end
        $display("test_priority: total=%0d bad=%0d", total, bad);
    endtask

    task automatic test_wrap;
        for (int k = 0; k < 87; k++) press(0, 1, 0);
        total++;
        if ({hi, lo} !== 8'h99) begin
            bad++;
            $display("FAIL min_99: got %h want 99", {hi, lo});
        end
        press(0, 1, 0);
        total++;
        if ({hi, lo} !== 8'h00) begin
            bad++;
            $display("FAIL min_wrap: got %h want 00", {hi, lo});
        end
        press(1, 0, 0);
        press(0, 1, 0);
        press(0, 1, 0);
        total++;
        if ({state_o, hi, lo} !== {3'd2, 4'd0, 4'd3}) begin
            bad++;
            $display("FAIL sec_03: got st=%0d %0d%0d want st=2 03", state_o, hi, lo);
        end
        press(1, 0, 0);
        $display("test_wrap: total=%0d bad=%0d", total, bad);
    endtask

    task automatic test_run_done;
        int high;
        set_digits(4'd0, 4'd0, 3'd0, 4'd3);
        press(0, 0, 1);
        sec_lo = 4'd2;
        @(negedge clk);
        sec_lo = 4'd1;
        @(negedge clk);
        sec_lo = 4'd0;
        total++;
        if ({state_o, enabled} !== {3'd3, 1'b1}) begin
            bad++;
            $display("FAIL still_run: got st=%0d en=%0d want st=3 en=1", state_o, enabled);
        end
        @(negedge clk);
        total++;
        if ({state_o, enabled, alarm} !== {3'd5, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL done_entry: got st=%0d en=%0d al=%0d want st=5 en=0 al=1", state_o, enabled, alarm);
        end
        high = alarm ? 1 : 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (alarm !== 1'b1) break;
            high++;
        end
        total++;
        if (high !== 4 || state_o !== 3'd5) begin
            bad++;
            $display("FAIL alarm_len: got %0d cycles st=%0d want 4 cycles st=5", high, state_o);
        end
        press(0, 0, 1);
        total++;
        if ({state_o, alarm} !== {3'd0, 1'b0}) begin
            bad++;
            $display("FAIL done_ack: got st=%0d al=%0d want st=0 al=0", state_o, alarm);
        end
        $display("test_run_done: total=%0d bad=%0d", total, bad);
    endtask

    task automatic test_mask_and_reset;
        set_digits(4'd0, 4'd0, 3'd0, 4'd0);
        press(0, 0, 1);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            total++;
            if (state_o !== 3'd3) begin
                bad++;
                $display("FAIL mask_cycle%0d: got st=%0d want 3", k, state_o);
            end
        end
        @(negedge clk);
        total++;
        if ({state_o, alarm} !== {3'd5, 1'b1}) begin
            bad++;
            $display("FAIL mask_done: got st=%0d al=%0d want st=5 al=1", state_o, alarm);
        end
        press(1, 1, 0);
        total++;
        if ({state_o, alarm} !== {3'd5, 1'b1}) begin
            bad++;
            $display("FAIL done_ignores_set: got st=%0d al=%0d want st=5 al=1", state_o, alarm);
        end
        press(0, 0, 1);
        total++;
        if ({state_o, alarm, enabled} !== {3'd0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL alarm_abort: got st=%0d al=%0d en=%0d want 0 0 0", state_o, alarm, enabled);
        end
        set_digits(4'd0, 4'd0, 3'd0, 4'd3);
        press(0, 0, 1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #0.5;
        total++;
        if ({state_o, enabled, paused, alarm, hi, lo} !== 14'd0) begin
            bad++;
            $display("FAIL async_reset: got %h want 0", {state_o, enabled, paused, alarm, hi, lo});
        end
        #0.5 rst_n = 1'b1;
        press(0, 0, 1);
        total++;
        if ({state_o, enabled} !== {3'd0, 1'b0}) begin
            bad++;
            $display("FAIL start_zero_ignored: got st=%0d en=%0d want st=0 en=0", state_o, enabled);
        end
        press(1, 0, 0);
        total++;
        if ({state_o, hi, lo} !== {3'd1, 4'd0, 4'd0}) begin
            bad++;
            $display("FAIL preset_cleared: got st=%0d %0d%0d want st=1 00", state_o, hi, lo);
        end
        $display("test_mask_and_reset: total=%0d bad=%0d", total, bad);
    endtask

    initial begin
        test_reset;
        test_preset;
        test_pause_abort;
        test_priority;
        test_wrap;
        test_run_done;
        test_mask_and_reset;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
